// File: rtl/bcd_display_conv_if.sv
// Handshake and result bundle between a value source and the BCD/7-seg converter.
interface bcd_display_conv_if #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [WIDTH-1:0]      val;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;
  logic                  neg;
  logic                  overflow;

  modport master (output start, val,
                  input  busy, done, bcd, seg, neg, overflow);
  modport slave  (input  start, val,
                  output busy, done, bcd, seg, neg, overflow);
endinterface

// File: rtl/bcd_display_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) driving
// DIGITS active-low seven-segment displays with blanking and saturation.
module bcd_display_conv #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DIGITS = 2,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned LZB    = 1
) (
  input  logic clk,
  input  logic rst_n,
  bcd_display_conv_if.slave bus
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned SW = 7 * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] shreg, shreg_shifted, mag;
  logic [BW-1:0]   scratch, scratch_shifted, adj;
  logic [CW-1:0]   cnt;
  logic            ovf, ovf_final, carry, neg_pend, is_neg, accept;
  logic [BW-1:0]   bcd_final, bcd_q;
  logic [SW-1:0]   seg_final, seg_q;
  logic            neg_q, ovf_q, lead;
  logic [3:0]      dg;
  int unsigned     idx;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Negating in WIDTH bits still yields the right unsigned magnitude for the most-negative input.
  always_comb begin
    is_neg = (SIGNED != 0) && bus.val[WIDTH-1];
    mag    = is_neg ? (~bus.val + 1'b1) : bus.val;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        accept     = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: if (cnt == '0) state_next = FINISH;
      FINISH: if (bus.start) begin
        accept     = 1'b1;
        state_next = SHIFT;
      end else begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                  : scratch[4*i +: 4];
    end
    {carry, scratch_shifted, shreg_shifted} = {adj, shreg, 1'b0};
    ovf_final = ovf | carry;
  end

  // Walk digits from the top so blanking stops at the first non-zero digit.
  always_comb begin
    bcd_final = '0;
    seg_final = '1;
    lead      = 1'b1;
    dg        = '0;
    idx       = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx = DIGITS - 1 - k;
      dg  = ovf_final ? 4'h9 : scratch_shifted[4*idx +: 4];
      bcd_final[4*idx +: 4] = dg;
      if (dg != 4'd0 || idx == 0) lead = 1'b0;
      seg_final[7*idx +: 7] = (LZB != 0 && lead) ? 7'h7F : seg_code(dg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      neg_pend <= 1'b0;
      bcd_q    <= '0;
      seg_q    <= '1;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        shreg    <= mag;
        scratch  <= '0;
        cnt      <= CW'(WIDTH - 1);
        ovf      <= 1'b0;
        neg_pend <= is_neg;
      end else if (state == SHIFT) begin
        shreg   <= shreg_shifted;
        scratch <= scratch_shifted;
        cnt     <= cnt - 1'b1;
        ovf     <= ovf_final;
        if (cnt == '0) begin
          bcd_q <= bcd_final;
          seg_q <= seg_final;
          neg_q <= neg_pend;
          ovf_q <= ovf_final;
        end
      end
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == FINISH);
  assign bus.bcd      = bcd_q;
  assign bus.seg      = seg_q;
  assign bus.neg      = neg_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bcd_display_conv.sv
// Bench for bcd_display_conv: two configurations driven in lockstep, checked
// every cycle against an arithmetic reference model plus directed literals.
module tb_bcd_display_conv;
  logic       clk, rst_n;
  logic       start_s;
  logic [7:0] val_s;
  int         checks = 0;
  int         errors = 0;
  bit         cmp_en = 0;

  bcd_display_conv_if #(.WIDTH(7), .DIGITS(2)) ifa ();
  bcd_display_conv_if #(.WIDTH(8), .DIGITS(3)) ifb ();

  assign ifa.start = start_s;
  assign ifa.val   = val_s[6:0];
  assign ifb.start = start_s;
  assign ifb.val   = val_s;

  bcd_display_conv #(.WIDTH(7), .DIGITS(2), .SIGNED(0), .LZB(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  bcd_display_conv #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .LZB(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int          left;
    int unsigned pend;
    logic [63:0] bcd;
    logic [63:0] seg;
    bit          neg;
    bit          ovf;
    bit          done;
  } model_t;

  model_t ma, mb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_conv(input int unsigned v, input int w, input int d,
                                   input bit sgn, input bit lzb,
                                   output logic [63:0] bcd, output logic [63:0] seg,
                                   output bit neg, output bit ovf);
    int unsigned mag, p, digit;
    bit blank;
    neg = sgn && (((v >> (w - 1)) & 1) == 1);
    mag = neg ? (32'd1 << w) - v : v;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    ovf = (mag > p - 1);
    bcd = '0;
    seg = '0;
    p = 1;
    for (int k = 0; k < d; k++) begin
      digit = ovf ? 9 : (mag / p) % 10;
      blank = lzb && !ovf && (k > 0) && (mag < p);
      bcd = bcd | (64'(digit) << (4 * k));
      seg = seg | (64'(blank ? 7'h7F : segtab[digit]) << (7 * k));
      p = p * 10;
    end
  endfunction

  function automatic void mreset(inout model_t m, input int d);
    m.left = 0; m.pend = 0; m.bcd = '0; m.neg = 0; m.ovf = 0; m.done = 0;
    m.seg = (64'd1 << (7 * d)) - 1;
  endfunction

  function automatic void step(inout model_t m, input bit st, input int unsigned v,
                               input int w, input int d, input bit sgn);
    m.done = 0;
    if (m.left > 0) begin
      m.left--;
      if (m.left == 0) begin
        ref_conv(m.pend, w, d, sgn, 1'b1, m.bcd, m.seg, m.neg, m.ovf);
        m.done = 1;
      end
    end else if (st) begin
      m.left = w;
      m.pend = v;
    end
  endfunction

  initial begin
    mreset(ma, 2);
    mreset(mb, 3);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreset(ma, 2);
      mreset(mb, 3);
    end else begin
      step(ma, start_s, int'(val_s[6:0]), 7, 2, 1'b0);
      step(mb, start_s, int'(val_s), 8, 3, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_busy", 64'(ifa.busy), 64'(ma.left > 0));
      chk("a_done", 64'(ifa.done), 64'(ma.done));
      chk("a_bcd",  64'(ifa.bcd),  ma.bcd);
      chk("a_seg",  64'(ifa.seg),  ma.seg);
      chk("a_neg",  64'(ifa.neg),  64'(ma.neg));
      chk("a_ovf",  64'(ifa.overflow), 64'(ma.ovf));
      chk("b_busy", 64'(ifb.busy), 64'(mb.left > 0));
      chk("b_done", 64'(ifb.done), 64'(mb.done));
      chk("b_bcd",  64'(ifb.bcd),  mb.bcd);
      chk("b_seg",  64'(ifb.seg),  mb.seg);
      chk("b_neg",  64'(ifb.neg),  64'(mb.neg));
      chk("b_ovf",  64'(ifb.overflow), 64'(mb.ovf));
    end
  end

  task automatic start_and_wait(input logic [7:0] v, output int ka, output int kb);
    ka = 0;
    kb = 0;
    @(negedge clk);
    start_s = 1'b1;
    val_s   = v;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (ifa.done && ka == 0) ka = k;
      if (ifb.done && kb == 0) kb = k;
      if (ka != 0 && kb != 0) break;
    end
  endtask

  initial begin
    logic [63:0] rb, rs;
    bit rn, ro;
    int ka, kb, k2, dcnt;

    ref_conv(99, 7, 2, 0, 1, rb, rs, rn, ro);
    chk("model_99_bcd", rb, 64'h99);
    chk("model_99_seg", rs, 64'h0810);
    ref_conv(7, 7, 2, 0, 1, rb, rs, rn, ro);
    chk("model_7_seg", rs, 64'h3FF8);
    ref_conv(0, 7, 2, 0, 1, rb, rs, rn, ro);
    chk("model_0_seg", rs, 64'h3FC0);
    ref_conv(127, 7, 2, 0, 1, rb, rs, rn, ro);
    chk("model_127_ovf", {rb[62:0], ro}, {63'h99, 1'b1});
    ref_conv(128, 8, 3, 1, 1, rb, rs, rn, ro);
    chk("model_m128", {rb[62:0], rn}, {63'h128, 1'b1});

    rst_n   = 1'b0;
    start_s = 1'b0;
    val_s   = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_seg",  64'(ifa.seg),  64'h3FFF);
    chk("rst_b_seg",  64'(ifb.seg),  64'h1FFFFF);
    chk("rst_a_bcd",  64'(ifa.bcd),  64'h0);
    chk("rst_a_busy", 64'({ifa.busy, ifa.done, ifb.busy, ifb.done}), 64'h0);
    #2 rst_n = 1'b1;
    cmp_en = 1;

    start_and_wait(8'd99, ka, kb);
    chk("lat_a", 64'(ka), 64'd8);
    chk("lat_b", 64'(kb), 64'd9);
    chk("d99_a_bcd", 64'(ifa.bcd), 64'h99);
    chk("d99_a_seg", 64'(ifa.seg), 64'h0810);
    chk("d99_b_seg", 64'(ifb.seg), 64'h1FC810);

    start_and_wait(8'd7, ka, kb);
    chk("d7_a_bcd", 64'(ifa.bcd), 64'h07);
    chk("d7_a_seg", 64'(ifa.seg), 64'h3FF8);
    start_and_wait(8'd0, ka, kb);
    chk("d0_a_seg", 64'(ifa.seg), 64'h3FC0);

    start_and_wait(8'd127, ka, kb);
    chk("d127_a", 64'({ifa.overflow, ifa.bcd}), 64'h199);
    chk("d127_b", 64'({ifb.overflow, ifb.neg, ifb.bcd}), 64'h0127);
    start_and_wait(8'd42, ka, kb);
    chk("d42_a", 64'({ifa.overflow, ifa.bcd}), 64'h042);

    start_and_wait(8'h80, ka, kb);
    chk("m128_b", 64'({ifb.neg, ifb.bcd}), 64'h1128);
    start_and_wait(8'hFF, ka, kb);
    chk("m1_b", 64'({ifb.neg, ifb.bcd}), 64'h1001);
    chk("m1_b_seg", 64'(ifb.seg), 64'h1FFFF9);

    // Second start during SHIFT must be dropped.
    @(negedge clk);
    start_s = 1'b1; val_s = 8'd5;
    @(negedge clk); start_s = 1'b0;
    @(negedge clk); start_s = 1'b1; val_s = 8'd77;
    @(negedge clk); start_s = 1'b0;
    ka = 0;
    for (int k = 0; k < 30 && ka == 0; k++) begin
      @(negedge clk);
      if (ifa.done) ka = 1;
    end
    chk("busy_ignore", 64'({ka[0], ifa.bcd}), 64'h105);
    repeat (4) @(negedge clk);

    @(negedge clk);
    start_s = 1'b1; val_s = 8'd12;
    ka = 0; k2 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (ifa.done) begin
        if (ka == 0) begin
          ka = k; start_s = 1'b1; val_s = 8'd34;
        end else begin
          k2 = k;
          break;
        end
      end
    end
    chk("b2b_lat", 64'(k2 - ka), 64'd8);
    chk("b2b_bcd", 64'(ifa.bcd), 64'h34);
    repeat (3) @(negedge clk);

    @(negedge clk);
    start_s = 1'b1; val_s = 8'd50;
    @(negedge clk); start_s = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'({ifa.busy, ifb.busy}), 64'h0);
    chk("mid_rst_seg",  64'(ifa.seg), 64'h3FFF);
    chk("mid_rst_bcd",  64'(ifb.bcd), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ifa.done || ifb.done) dcnt++;
    end
    chk("no_done_after_rst", 64'(dcnt), 64'd0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start_s = ($urandom_range(0, 2) == 0);
      val_s   = 8'($urandom);
    end
    @(negedge clk);
    start_s = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
